adc_pattern_gen: RTL
====================

# adc_pattern_gen

Multi-channel ADC stimulus generator, successor to the single-channel triangle emulator. It produces programmable ramp, triangle, constant and optional PRBS sample streams on CHANNELS parallel lanes. Samples are paced by a programmable decimation divider and delivered over a valid/ready handshake. It sits in place of the ADC front end during bring-up and feeds the capture/DMA path with known data.

## Interface
- WIDTH, 16: sample width per channel, 4..32.
- CHANNELS, 4: number of output lanes, 1..8.
- STEP_W, 8: width of step input, ≤ WIDTH.
- CH_OFFSET, 2**(WIDTH-2): per-lane value offset; lane k adds k*CH_OFFSET, mod 2**WIDTH.

Ports:
- clk  in  1  sample clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run; when low the divider and generator freeze, pending sample is kept.
- mode  in  2  0 ramp, 1 triangle, 2 constant, 3 PRBS.
- step  in  STEP_W  increment for ramp/triangle; constant value (zero-extended) for mode 2.
- decim  in  8  tick every decim+1 enabled cycles.
- out_data  out  CHANNELS*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  sample pending.
- out_ready  in  1  consumer accepts when valid&&ready.
- overrun  out  1  sticky: a tick was lost while a sample was pending.
- clr_overrun  in  1  synchronous clear of overrun.

## Operation
- Reset: acc=0, dir=up, div=0, last_mode=0, out_data=0, out_valid=0, overrun=0, LFSR state all ones.
- Divider: counts enabled cycles 0..decim. Tick occurs when div==decim, then div wraps to 0. decim=0 means a tick on every enabled cycle.
- On a tick with no pending sample (out_valid==0, or a handshake completes in the same cycle):
  - the generator advances;
  - out_data loads from the new acc;
  - out_valid=1.
- On a tick with a sample pending and no handshake: the generator does not advance, out_data is held, and overrun is set.
- Handshake with no tick: out_valid=0.
- Mode change: mode is sampled at each tick. If it differs from last_mode, acc=0, dir=up and the LFSR is reseeded to all ones before the update; the first sample of the new mode is then computed from that state.
- Ramp: acc = acc+step, mod 2**WIDTH, wraps.
- Triangle (saturating, no wrap):
  - going up: if acc+step ≥ 2**WIDTH-1, acc=2**WIDTH-1 and dir=down; otherwise acc+=step.
  - going down: if acc ≤ step, acc=0 and dir=up; otherwise acc-=step.
  - step=0 holds the value.
- Constant: acc = zero-extended step.
- PRBS: 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, advances one shift per tick. acc = low WIDTH bits.
- Lane k = acc + k*CH_OFFSET, mod 2**WIDTH, in every mode.
- clr_overrun and a simultaneous overrun event: the set wins.
- Reset mid-stream: everything returns to reset values immediately; any pending sample is discarded.

## Timing
- Tick to out_valid: out_valid rises on the clock edge that ends the tick cycle (1 cycle). Data is registered, with no combinational path from inputs to out_data.
- out_data and out_valid are stable while out_valid && !out_ready.
- Maximum throughput: one sample per cycle with decim=0 and out_ready tied high.
- enable low: div and generator hold. out_valid and out_data hold, and the handshake still completes if ready.

## Configuration
- ADC_PATTERN_PRBS_EN:
  - Defined: mode 3 is PRBS and the 32-bit LFSR is built.
  - Undefined: the LFSR is not instantiated and mode 3 behaves exactly as ramp, including the mode-change restart rule.

## Test plan
- WIDTH=8, CHANNELS=2, CH_OFFSET=64, mode 0, step=1, decim=0, ready=1 -> lane0 1,2,…,255,0; lane1 65,66,…, wraps 255->0.
- WIDTH=8, mode 1, step=100 -> lane0 100,200,255,155,55,0,100; dir flips exactly at 255 and at 0.
- decim=3, ready=1 -> out_valid pulses every 4th cycle; enable low for 5 cycles stretches the interval by 5.
- ready=0 for 3 ticks, then 1 -> first sample is held unchanged, overrun=1, generator resumes from the held value +step; clr_overrun clears overrun unless a tick is lost in the same cycle.
- Mode 2 with step=0x5A, then switch to mode 0 with step=1 -> constant 0x5A samples, then the first ramp sample is 1 (restart from 0).
- With ADC_PATTERN_PRBS_EN, mode 3, WIDTH=32 -> first sample equals one LFSR shift of 0xFFFFFFFF; reset asserted mid-stream -> out_valid=0 and out_data=0 immediately, and the next PRBS sequence repeats from the seed.

Source files
------------

// File: rtl/adc_pattern_gen.sv
// adc_pattern_gen: multi-lane ramp/triangle/constant/PRBS sample source, paced by a decimation divider, valid/ready output.
// Build option: define ADC_PATTERN_PRBS_EN to include the 32-bit LFSR for mode 3; otherwise mode 3 is a ramp.

module adc_pattern_lane #(
    parameter int     WIDTH     = 16,
    parameter int     LANE      = 0,
    parameter longint CH_OFFSET = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] data
);
    localparam longint           LANE_OFF = longint'(LANE) * CH_OFFSET;
    localparam logic [WIDTH-1:0] OFF      = WIDTH'(LANE_OFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data <= '0;
        else if (load)
            data <= acc + OFF;
    end
endmodule

module adc_pattern_gen #(
    parameter int     WIDTH     = 16,
    parameter int     CHANNELS  = 4,
    parameter int     STEP_W    = 8,
    parameter longint CH_OFFSET = longint'(1) << (WIDTH - 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [STEP_W-1:0]         step,
    input  logic [7:0]                decim,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun,
    input  logic                      clr_overrun
);
    typedef enum logic [1:0] {MODE_RAMP, MODE_TRI, MODE_CONST, MODE_PRBS} mode_e;

    localparam logic [WIDTH-1:0] ACC_MAX = '1;

    logic [7:0]                     div;
    logic [WIDTH-1:0]               acc, acc_nxt, acc_base, step_ext;
    logic                           dir_down, dir_nxt, dir_base;
    logic [1:0]                     last_mode;
    logic                           tick, hs, advance, lost, restart;
    logic [WIDTH:0]                 tri_sum;
    logic [CHANNELS-1:0][WIDTH-1:0] lane_q;

    // >= rather than == so a decim lowered below the running count ticks at once instead of wrapping 256.
    assign tick     = enable && (div >= decim);
    assign hs       = out_valid && out_ready;
    assign advance  = tick && (!out_valid || hs);
    assign lost     = tick && out_valid && !hs;
    assign restart  = (mode != last_mode);
    assign step_ext = WIDTH'(step);
    assign acc_base = restart ? '0 : acc;
    assign dir_base = restart ? 1'b0 : dir_down;
    assign tri_sum  = {1'b0, acc_base} + {1'b0, step_ext};

`ifdef ADC_PATTERN_PRBS_EN
    logic [31:0] lfsr, lfsr_base, lfsr_nxt;

    assign lfsr_base = restart ? '1 : lfsr;
    assign lfsr_nxt  = {lfsr_base[30:0], lfsr_base[31] ^ lfsr_base[21] ^ lfsr_base[1] ^ lfsr_base[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= '1;
        else if (advance)
            lfsr <= lfsr_nxt;
    end
`endif

    always_comb begin
        acc_nxt = acc_base + step_ext;
        dir_nxt = dir_base;
        case (mode_e'(mode))
            MODE_TRI: begin
                if (!dir_base) begin
                    if (tri_sum >= {1'b0, ACC_MAX}) begin
                        acc_nxt = ACC_MAX;
                        dir_nxt = 1'b1;
                    end else begin
                        acc_nxt = tri_sum[WIDTH-1:0];
                    end
                end else if (acc_base <= step_ext) begin
                    acc_nxt = '0;
                    dir_nxt = 1'b0;
                end else begin
                    acc_nxt = acc_base - step_ext;
                end
            end
            MODE_CONST: acc_nxt = step_ext;
`ifdef ADC_PATTERN_PRBS_EN
            MODE_PRBS:  acc_nxt = lfsr_nxt[WIDTH-1:0];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            acc       <= '0;
            dir_down  <= 1'b0;
            last_mode <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (enable)
                div <= tick ? 8'd0 : div + 8'd1;
            if (advance) begin
                acc       <= acc_nxt;
                dir_down  <= dir_nxt;
                last_mode <= mode;
            end
            if (advance)
                out_valid <= 1'b1;
            else if (hs)
                out_valid <= 1'b0;
            if (lost)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        adc_pattern_lane #(
            .WIDTH    (WIDTH),
            .LANE     (k),
            .CH_OFFSET(CH_OFFSET)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .load (advance),
            .acc  (acc_nxt),
            .data (lane_q[k])
        );
    end

    assign out_data = lane_q;
endmodule
